// File: rtl/vector_burst_loader.sv
// vector_burst_loader
// Reads a burst of 1..LANES words from the word memory, packs them into one
// vector and writes that vector to a register-file entry in a single cycle.
// Optional feature: define VECTOR_LOADER_BOUNDS_CHECK_EN to reject bursts that
// would run past the top of memory (error pulse) instead of wrapping.

module vector_burst_loader #(
   parameter int ADDR_W  = 9,
   parameter int WORD_W  = 32,
   parameter int LANES   = 16,
   parameter int MEM_LAT = 1,
   localparam int LEN_W  = $clog2(LANES),
   localparam int CNT_W  = LEN_W + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [LEN_W-1:0]          burst_len,
   input  logic [1:0]                dest_reg,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_rd_en,
   output logic                      mem_burst_enable,
   output logic [LEN_W-1:0]          mem_burst_length,
   input  logic [WORD_W-1:0]         mem_data_out,
   output logic                      rf_write_enable,
   output logic [1:0]                rf_sel_reg_write,
   output logic [LANES*WORD_W-1:0]   rf_data
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      WRITEBACK
   } state_t;

   state_t                          state;
   state_t                          state_next;
   logic [ADDR_W-1:0]               base_q;
   logic [LEN_W-1:0]                len_q;
   logic [1:0]                      dest_q;
   logic [LEN_W-1:0]                issue_cnt;
   logic [CNT_W-1:0]                cap_cnt;
   logic [CNT_W-1:0]                cap_total;
   logic [CNT_W-1:0]                len_plus1;
   logic [MEM_LAT-1:0]              vld_pipe;
   logic                            cap_valid;
   logic [LANES-1:0][WORD_W-1:0]    lanes;
   logic                            reject;
   logic                            accept;

`ifdef VECTOR_LOADER_BOUNDS_CHECK_EN
   localparam int SUM_W = ADDR_W + 1;
   logic [SUM_W-1:0]                end_addr;
   logic                            error_q;

   assign end_addr = {1'b0, base_addr} + SUM_W'(burst_len);
   assign reject   = end_addr[ADDR_W];
   assign error    = error_q;

   // Pulse error in the cycle after a rejected request was seen in IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         error_q <= 1'b0;
      end else begin
         error_q <= start && (state == IDLE) && reject;
      end
   end
`else
   assign reject = 1'b0;
   assign error  = 1'b0;
`endif

   assign accept    = (state == IDLE) && start && !reject;
   assign cap_valid = vld_pipe[MEM_LAT-1];
   assign cap_total = cap_cnt + {{LEN_W{1'b0}}, cap_valid};
   assign len_plus1 = {1'b0, len_q} + CNT_W'(1);
   assign rf_data   = lanes;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore outputs; DRAIN looks at the count including this
   // cycle's capture so writeback follows the last data word immediately
   always_comb begin
      state_next       = state;
      busy             = (state != IDLE);
      done             = 1'b0;
      mem_addr         = '0;
      mem_rd_en        = 1'b0;
      mem_burst_enable = 1'b0;
      mem_burst_length = '0;
      rf_write_enable  = 1'b0;
      rf_sel_reg_write = 2'd0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            mem_rd_en        = 1'b1;
            mem_burst_enable = 1'b1;
            mem_burst_length = len_q;
            mem_addr         = base_q + ADDR_W'(issue_cnt);
            if (issue_cnt == len_q) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (cap_total == len_plus1) begin
               state_next = WRITEBACK;
            end
         end
         WRITEBACK: begin
            rf_write_enable  = 1'b1;
            rf_sel_reg_write = dest_q;
            done             = 1'b1;
            state_next       = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Track in-flight reads so returning data is captured exactly MEM_LAT later
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= mem_rd_en;
         for (int i = 1; i < MEM_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   // Request latching, issue counting and lane capture into the vector buffer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         base_q    <= '0;
         len_q     <= '0;
         dest_q    <= '0;
         issue_cnt <= '0;
         cap_cnt   <= '0;
         lanes     <= '0;
      end else if (accept) begin
         base_q    <= base_addr;
         len_q     <= burst_len;
         dest_q    <= dest_reg;
         issue_cnt <= '0;
         cap_cnt   <= '0;
         lanes     <= '0;
      end else begin
         if (state == ISSUE) begin
            issue_cnt <= issue_cnt + LEN_W'(1);
         end
         if (cap_valid) begin
            lanes[cap_cnt[LEN_W-1:0]] <= mem_data_out;
            cap_cnt                   <= cap_cnt + CNT_W'(1);
         end
      end
   end

endmodule
